// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - 64-bit load/store initiator splitting each word into eight byte RAM accesses
module data_mem_ctrl #(
  parameter int ADDRESS_BUS_WIDTH = 10,
  parameter int DATA_BUS_WIDTH    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  input  logic                         we,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr,
  input  logic [DATA_BUS_WIDTH-1:0]    wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [DATA_BUS_WIDTH-1:0]    rdata,
  output logic                         mem_cs,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
  output logic [7:0]                   mem_wdata,
  input  logic [7:0]                   mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_TAIL = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Highest base address whose 8 bytes fit below the top of the address space.
  localparam logic [ADDRESS_BUS_WIDTH-1:0] C_ALL_ONES  = '1;
  localparam logic [ADDRESS_BUS_WIDTH-1:0] C_LAST_BASE = C_ALL_ONES - ADDRESS_BUS_WIDTH'(7);

  state_t                         r_state;
  logic [2:0]                     r_cnt;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_base;
  logic                           r_we;
  logic [DATA_BUS_WIDTH-1:0]      r_wdata;
  // Bytes 0..6 of a load; byte 7 goes straight from the RAM into rdata.
  logic [DATA_BUS_WIDTH-9:0]      r_asm;
  logic [DATA_BUS_WIDTH-1:0]      r_rdata;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_err;
  logic                           r_mem_cs;
  logic                           r_mem_read;
  logic                           r_mem_write;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_mem_addr;
  logic [7:0]                     r_mem_wdata;

  logic                           w_range_err;
  logic [2:0]                     w_cnt_nxt;
  logic [2:0]                     w_cnt_prev;
  logic [ADDRESS_BUS_WIDTH-1:0]   w_addr_nxt;
  logic [7:0]                     w_wbyte_nxt;

  assign w_range_err = (addr > C_LAST_BASE);
  assign w_cnt_nxt   = r_cnt + 3'd1;
  assign w_cnt_prev  = r_cnt - 3'd1;
  assign w_addr_nxt  = r_base + {{(ADDRESS_BUS_WIDTH-3){1'b0}}, w_cnt_nxt};
  assign w_wbyte_nxt = r_wdata[{w_cnt_nxt, 3'b000} +: 8];

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_cs    = r_mem_cs;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Controller FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_base      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_asm       <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;
    end else begin
      // Strobes and pulses default low; states that keep them high reassert below.
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;

      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_base  <= addr;
            r_we    <= we;
            r_wdata <= wdata;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b1;
            if (w_range_err) begin
              // Access would wrap past the top byte: report without touching RAM.
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (we) begin
              r_state     <= S_WR;
              r_mem_cs    <= 1'b1;
              r_mem_write <= 1'b1;
              r_mem_addr  <= addr;
              r_mem_wdata <= wdata[7:0];
            end else begin
              r_state    <= S_RD;
              r_mem_cs   <= 1'b1;
              r_mem_read <= 1'b1;
              r_mem_addr <= addr;
            end
          end
        end

        S_WR: begin
          if (r_cnt == 3'd7) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt       <= w_cnt_nxt;
            r_mem_cs    <= 1'b1;
            r_mem_write <= 1'b1;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wbyte_nxt;
          end
        end

        S_RD: begin
          // RAM data lags the read strobe by one cycle, so this edge carries byte cnt-1.
          if (r_cnt != 3'd0) begin
            for (int i = 0; i < 7; i++) begin
              if (w_cnt_prev == 3'(i)) begin
                r_asm[8*i +: 8] <= mem_rdata;
              end
            end
          end
          if (r_cnt == 3'd7) begin
            r_state <= S_RD_TAIL;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_mem_cs   <= 1'b1;
            r_mem_read <= 1'b1;
            r_mem_addr <= w_addr_nxt;
          end
        end

        S_RD_TAIL: begin
          r_rdata <= {mem_rdata, r_asm};
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 3'd0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [9:0]  addr;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rdata;
  logic        mem_cs;
  logic        mem_read;
  logic        mem_write;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int total;
  int bad;
  int wr_count;
  int rd_count;
  int overlap_count;
  logic [63:0] exp_rdata;
  logic [7:0]  ram [0:1023];

  data_mem_ctrl #(.ADDRESS_BUS_WIDTH(10), .DATA_BUS_WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_cs    (mem_cs),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural byte RAM with registered read data, plus access bookkeeping.
  always @(posedge clk) begin
    if (mem_cs && mem_write) begin
      ram[mem_addr] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
    if (mem_cs && mem_read) begin
      mem_rdata <= ram[mem_addr];
      rd_count <= rd_count + 1;
    end
    if (mem_read && mem_write) overlap_count <= overlap_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_store(input logic [9:0] a, input logic [63:0] d);
    int w0;
    int r0;
    w0 = wr_count;
    r0 = rd_count;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("st_write", {63'd0, mem_write}, 64'd1);
      chk("st_busy", {63'd0, busy}, 64'd1);
      chk("st_addr", {54'd0, mem_addr}, {54'd0, 10'(a + 10'(k))});
      chk("st_wdata", {56'd0, mem_wdata}, {56'd0, d[8*k +: 8]});
      @(negedge clk);
    end
    chk("st_done", {63'd0, done}, 64'd1);
    chk("st_err", {63'd0, err}, 64'd0);
    chk("st_cs_done", {63'd0, mem_cs}, 64'd0);
    chk("st_rdata_kept", rdata, exp_rdata);
    @(negedge clk);
    chk("st_idle_busy", {63'd0, busy}, 64'd0);
    chk("st_idle_done", {63'd0, done}, 64'd0);
    chk("st_wr_count", 64'(wr_count - w0), 64'd8);
    chk("st_rd_count", 64'(rd_count - r0), 64'd0);
  endtask

  task automatic run_load(input logic [9:0] a, input logic [63:0] exp);
    int r0;
    r0 = rd_count;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("ld_read", {63'd0, mem_read}, 64'd1);
      chk("ld_write", {63'd0, mem_write}, 64'd0);
      chk("ld_addr", {54'd0, mem_addr}, {54'd0, 10'(a + 10'(k))});
      @(negedge clk);
    end
    chk("ld_tail_cs", {63'd0, mem_cs}, 64'd0);
    chk("ld_tail_busy", {63'd0, busy}, 64'd1);
    chk("ld_tail_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    chk("ld_done", {63'd0, done}, 64'd1);
    chk("ld_err", {63'd0, err}, 64'd0);
    chk("ld_rdata", rdata, exp);
    exp_rdata = exp;
    @(negedge clk);
    chk("ld_idle_busy", {63'd0, busy}, 64'd0);
    chk("ld_rd_count", 64'(rd_count - r0), 64'd8);
  endtask

  initial begin
    int w0;
    int r0;
    total = 0; bad = 0;
    wr_count = 0; rd_count = 0; overlap_count = 0;
    mem_rdata = 8'd0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'd0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    exp_rdata = 64'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_cs", {63'd0, mem_cs}, 64'd0);
    chk("rst_addr", {54'd0, mem_addr}, 64'd0);
    rst_n = 1'b1;

    // Aligned store then load back.
    run_store(10'd16, 64'h0807060504030201);
    run_load(10'd16, 64'h0807060504030201);

    // Unaligned load.
    for (int i = 0; i < 8; i++) ram[3 + i] = 8'hA0 + 8'(i);
    run_load(10'd3, 64'hA7A6A5A4A3A2A1A0);

    // Wrapping address rejected without any RAM access.
    w0 = wr_count; r0 = rd_count;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 10'd1017;
    @(negedge clk);
    req = 1'b0;
    chk("er_done", {63'd0, done}, 64'd1);
    chk("er_err", {63'd0, err}, 64'd1);
    chk("er_cs", {63'd0, mem_cs}, 64'd0);
    chk("er_busy", {63'd0, busy}, 64'd1);
    chk("er_rdata", rdata, 64'hA7A6A5A4A3A2A1A0);
    @(negedge clk);
    chk("er_idle_busy", {63'd0, busy}, 64'd0);
    chk("er_idle_err", {63'd0, err}, 64'd0);
    chk("er_accesses", 64'((wr_count - w0) + (rd_count - r0)), 64'd0);

    // Top legal base address.
    for (int i = 0; i < 8; i++) ram[1016 + i] = 8'hC0 + 8'(i);
    run_load(10'd1016, 64'hC7C6C5C4C3C2C1C0);

    // req held high: store, then a load accepted on the first IDLE edge.
    w0 = wr_count; r0 = rd_count;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 10'd100; wdata = 64'h0F0E0D0C0B0A0908;
    @(negedge clk);
    we = 1'b0;
    chk("hold_st_addr", {54'd0, mem_addr}, 64'd100);
    chk("hold_st_wdata", {56'd0, mem_wdata}, 64'h08);
    repeat (8) @(negedge clk);
    chk("hold_st_done", {63'd0, done}, 64'd1);
    @(negedge clk);
    chk("hold_gap_busy", {63'd0, busy}, 64'd0);
    chk("hold_gap_cs", {63'd0, mem_cs}, 64'd0);
    @(negedge clk);
    req = 1'b0;
    chk("hold_ld_read", {63'd0, mem_read}, 64'd1);
    chk("hold_ld_addr", {54'd0, mem_addr}, 64'd100);
    repeat (9) @(negedge clk);
    chk("hold_ld_done", {63'd0, done}, 64'd1);
    chk("hold_ld_rdata", rdata, 64'h0F0E0D0C0B0A0908);
    exp_rdata = 64'h0F0E0D0C0B0A0908;
    @(negedge clk);
    chk("hold_end_busy", {63'd0, busy}, 64'd0);
    chk("hold_wr_count", 64'(wr_count - w0), 64'd8);
    chk("hold_rd_count", 64'(rd_count - r0), 64'd8);

    // req toggled while busy, and held through DONE, is ignored.
    w0 = wr_count; r0 = rd_count;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 10'd300; wdata = 64'h1122334455667788;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req = (k % 2 == 0) || (k == 8);
      we = 1'b0; addr = 10'd5;
    end
    @(negedge clk);
    chk("tog_done", {63'd0, done}, 64'd1);
    @(negedge clk);
    req = 1'b0;
    chk("tog_idle_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    chk("tog_after_busy", {63'd0, busy}, 64'd0);
    chk("tog_wr_count", 64'(wr_count - w0), 64'd8);
    chk("tog_rd_count", 64'(rd_count - r0), 64'd0);
    chk("tog_ram_lo", {56'd0, ram[300]}, 64'h88);
    chk("tog_ram_hi", {56'd0, ram[307]}, 64'h11);
    chk("tog_rdata", rdata, exp_rdata);

    // Reset during a store leaves partially written bytes in place.
    run_store(10'd0, 64'h1716151413121110);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 10'd0; wdata = 64'hB7B6B5B4B3B2B1B0;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rm_addr_cnt3", {54'd0, mem_addr}, 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rm_cs", {63'd0, mem_cs}, 64'd0);
    chk("rm_write", {63'd0, mem_write}, 64'd0);
    chk("rm_busy", {63'd0, busy}, 64'd0);
    chk("rm_rdata", rdata, 64'd0);
    exp_rdata = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_store(10'd200, 64'hDEADBEEF01234567);
    chk("rm_ram2", {56'd0, ram[2]}, 64'hB2);
    chk("rm_ram3", {56'd0, ram[3]}, 64'h13);
    run_load(10'd0, 64'h1716151413B2B1B0);

    chk("strobe_overlap", 64'(overlap_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
